// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - scoreboard monitor for a W-bit up/load counter (optional capture: COUNTER_MONITOR_CAPTURE_EN)
module counter_monitor #(
    parameter int W    = 4,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enb,
    input  logic            modo,
    input  logic [W-1:0]    data,
    input  logic [W-1:0]    Q,
    output logic            chk_valid,
    output logic            mismatch,
    output logic            err_sticky,
    output logic [ERRW-1:0] err_count,
    output logic [15:0]     check_count,
    output logic [1:0]      state,
    output logic [W-1:0]    first_exp,
    output logic [W-1:0]    first_obs,
    output logic [15:0]     first_idx
);

    typedef enum logic [1:0] {
        ST_RST  = 2'b00,
        ST_RUN  = 2'b01,
        ST_FAIL = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    exp_q, exp_d;
    logic            chk_valid_q, mismatch_q, err_sticky_q;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic [15:0]     chk_cnt_q;
    logic            miss;
    logic [W-1:0]    base;

    // Compare observed Q against the model; on a miss the model resyncs to Q
    always_comb begin
        miss = (Q != exp_q);
        base = miss ? Q : exp_q;
    end

    // Next model value follows the counter's own rules applied to the resynced base
    always_comb begin
        exp_d = base;
        if (enb) begin
            exp_d = modo ? data : base + W'(1);
        end
    end

    // Saturating error counter next value
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (miss && (err_cnt_q != {ERRW{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: leave RST on the first live edge, fall into FAIL on a miss while running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_RUN;
            ST_RUN:  state_d = miss ? ST_FAIL : ST_RUN;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_RST;
        endcase
    end

    // FSM output: expose the encoded state
    always_comb begin
        state = state_q;
    end

    // Model, comparison flags and counters; every live edge is one comparison
    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_q        <= '0;
            chk_valid_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
        end else begin
            exp_q        <= exp_d;
            chk_valid_q  <= 1'b1;
            mismatch_q   <= miss;
            err_sticky_q <= err_sticky_q | miss;
            err_cnt_q    <= err_cnt_d;
            chk_cnt_q    <= chk_cnt_q + 16'd1;
        end
    end

    assign chk_valid   = chk_valid_q;
    assign mismatch    = mismatch_q;
    assign err_sticky  = err_sticky_q;
    assign err_count   = err_cnt_q;
    assign check_count = chk_cnt_q;

`ifdef COUNTER_MONITOR_CAPTURE_EN
    logic [W-1:0] first_exp_q, first_obs_q;
    logic [15:0]  first_idx_q;

    // Snapshot the first miss since reset; index is the count of earlier comparisons
    always_ff @(posedge clk) begin
        if (!rst) begin
            first_exp_q <= '0;
            first_obs_q <= '0;
            first_idx_q <= '0;
        end else if (miss && !err_sticky_q) begin
            first_exp_q <= exp_q;
            first_obs_q <= Q;
            first_idx_q <= chk_cnt_q;
        end
    end

    assign first_exp = first_exp_q;
    assign first_obs = first_obs_q;
    assign first_idx = first_idx_q;
`else
    assign first_exp = '0;
    assign first_obs = '0;
    assign first_idx = '0;
`endif

endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - directed plus randomized self-checking bench for counter_monitor
module tb_counter_monitor;

`ifdef COUNTER_MONITOR_CAPTURE_EN
    localparam bit CAPTURE = 1'b1;
`else
    localparam bit CAPTURE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enb = 1'b0;
    logic        modo = 1'b0;
    logic [3:0]  data = '0;
    logic [3:0]  Q = '0;
    logic        chk_valid, mismatch, err_sticky;
    logic [7:0]  err_count;
    logic [15:0] check_count;
    logic [1:0]  state;
    logic [3:0]  first_exp, first_obs;
    logic [15:0] first_idx;

    int checks = 0;
    int failures = 0;

    // reference model: plain integers following the monitor's rules
    int m_exp, m_cc, m_ec, m_sticky, m_state, m_cv, m_mm, m_fe, m_fo, m_fi;
    int c;
    bit saw_wrap_15_0, saw_wrap_0_1;

    counter_monitor #(.W(4), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .enb(enb), .modo(modo), .data(data), .Q(Q),
        .chk_valid(chk_valid), .mismatch(mismatch), .err_sticky(err_sticky),
        .err_count(err_count), .check_count(check_count), .state(state),
        .first_exp(first_exp), .first_obs(first_obs), .first_idx(first_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_exp = 0; m_cc = 0; m_ec = 0; m_sticky = 0; m_state = 0;
        m_cv = 0; m_mm = 0; m_fe = 0; m_fo = 0; m_fi = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".chk_valid"},   32'(chk_valid),   m_cv);
        check({tag, ".mismatch"},    32'(mismatch),    m_mm);
        check({tag, ".err_sticky"},  32'(err_sticky),  m_sticky);
        check({tag, ".err_count"},   32'(err_count),   m_ec);
        check({tag, ".check_count"}, 32'(check_count), m_cc);
        check({tag, ".state"},       32'(state),       m_state);
        check({tag, ".first_exp"},   32'(first_exp),   m_fe);
        check({tag, ".first_obs"},   32'(first_obs),   m_fo);
        check({tag, ".first_idx"},   32'(first_idx),   m_fi);
    endtask

    // drive one cycle, advance the model by the same rules, then compare after the edge
    task automatic step(input string tag, input bit r, input bit e, input bit m, input int d, input int q);
        bit miss;
        int base;
        rst = r; enb = e; modo = m; data = d[3:0]; Q = q[3:0];
        if (!r) begin
            model_clear();
        end else begin
            miss = (q % 16) != m_exp;
            m_cv = 1;
            m_mm = miss;
            if (miss && m_sticky == 0 && CAPTURE) begin
                m_fe = m_exp; m_fo = q % 16; m_fi = m_cc;
            end
            if (miss) begin
                if (m_ec < 255) m_ec++;
                m_sticky = 1;
            end
            if (m_state == 0) m_state = 1;
            else if (m_state == 1 && miss) m_state = 2;
            m_cc = (m_cc + 1) % 65536;
            base = miss ? q % 16 : m_exp;
            if (e) m_exp = m ? d % 16 : (base + 1) % 16;
            else   m_exp = base;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_clear();
        // reset state
        step("rst0", 0, 0, 0, 0, 0);
        step("rst1", 0, 0, 0, 0, 0);
        check("reset_state", 32'(state), 0);

        // release with Q=0 held, enable low
        for (int i = 0; i < 3; i++) step("idle", 1, 0, 0, 0, 0);
        check("idle_check_count", 32'(check_count), 3);
        check("idle_state", 32'(state), 1);

        // correct counter through the 15->0 wrap
        c = 0;
        for (int i = 0; i < 18; i++) begin
            if (c == 15) saw_wrap_15_0 = 1;
            if (c == 0 && i > 0) saw_wrap_0_1 = 1;
            step("count", 1, 1, 0, 0, c);
            c = (c + 1) % 16;
        end
        check("count_wrapped", 32'(saw_wrap_15_0 & saw_wrap_0_1), 1);
        check("count_err_count", 32'(err_count), 0);
        check("count_err_sticky", 32'(err_sticky), 0);

        // parallel load followed by the correct value
        step("load", 1, 1, 1, 'hA, c);
        step("load_ok", 1, 0, 0, 0, 'hA);
        check("load_ok_mismatch", 32'(mismatch), 0);

        // second run: load A, counter shows 9
        step("rst_a", 0, 0, 0, 0, 0);
        step("run2_0", 1, 0, 0, 0, 0);
        step("run2_ld", 1, 1, 1, 'hA, 0);
        step("run2_bad", 1, 0, 0, 0, 'h9);
        check("bad_mismatch", 32'(mismatch), 1);
        check("bad_err_count", 32'(err_count), 1);
        check("bad_state", 32'(state), 2);
        check("bad_first_exp", 32'(first_exp), CAPTURE ? 'hA : 0);
        check("bad_first_obs", 32'(first_obs), CAPTURE ? 'h9 : 0);
        check("bad_first_idx", 32'(first_idx), CAPTURE ? 2 : 0);

        // 300 consecutive wrong observations
        for (int i = 0; i < 300; i++)
            step("flood", 1, 0, 0, 0, (m_exp + 1 + int'($urandom_range(0, 14))) % 16);
        check("flood_err_count_sat", 32'(err_count), 255);
        check("flood_sticky", 32'(err_sticky), 1);
        check("flood_first_idx", 32'(first_idx), CAPTURE ? 2 : 0);
        check("flood_state", 32'(state), 2);

        // reset for one cycle while in FAIL
        step("fail_rst", 0, 1, 0, 0, 5);
        check("fail_rst_state", 32'(state), 0);
        check("fail_rst_err_count", 32'(err_count), 0);
        check("fail_rst_chk_valid", 32'(chk_valid), 0);
        step("after_rst", 1, 0, 0, 0, 0);
        check("after_rst_state", 32'(state), 1);

        // randomized traffic: mostly a correct counter, occasional faults and resets
        for (int i = 0; i < 400; i++) begin
            bit r, e, m;
            int d, q;
            r = ($urandom_range(0, 39) != 0);
            e = $urandom_range(0, 3) != 0;
            m = $urandom_range(0, 3) == 0;
            d = int'($urandom_range(0, 15));
            q = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : m_exp;
            step("rand", r, e, m, d, q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter W, default 4: counter data width in bits.
REQ-002 Parameter ERRW, default 8: width of the error counter.
REQ-003 The module SHALL have the port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 The module SHALL have the port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have the port enb, input, 1 bit: counter enable, sampled from the stimulus bus.
REQ-006 The module SHALL have the port modo, input, 1 bit: 0 = increment, 1 = parallel load of data.
REQ-007 The module SHALL have the port data, input, W bits: load value.
REQ-008 The module SHALL have the port Q, input, W bits: observed counter output from the unit under test.
REQ-009 The module SHALL have the port chk_valid, output, 1 bit: pulses high on each cycle a comparison is made.
REQ-010 The module SHALL have the port mismatch, output, 1 bit: pulses high when the comparison fails.
REQ-011 The module SHALL have the port err_sticky, output, 1 bit: set on the first mismatch and held until reset.
REQ-012 The module SHALL have the port err_count, output, ERRW bits: mismatch count, saturating.
REQ-013 The module SHALL have the port check_count, output, 16 bits: comparison count, wrapping.
REQ-014 The module SHALL have the port state, output, 2 bits: FSM state (RST=00, RUN=01, FAIL=10).
REQ-015 The module SHALL have the port first_exp, output, W bits: expected value at the first mismatch.
REQ-016 The module SHALL have the port first_obs, output, W bits: observed value at the first mismatch.
REQ-017 The module SHALL have the port first_idx, output, 16 bits: check_count value at the first mismatch.

Function
REQ-018 The monitor SHALL hold an internal model register exp (W bits) that predicts the counter's Q.
REQ-019 A comparison SHALL occur at every rising edge with rst=1: chk_valid=1 and mismatch=(Q!=exp), both registered and visible one cycle later.
REQ-020 Model update at each rising edge with rst=1:
- base = Q on a mismatch (resync), otherwise exp;
- enb=1, modo=0: exp <= base+1 mod 2^W (15 -> 0 for W=4);
- enb=1, modo=1: exp <= data;
- enb=0: exp <= base.
REQ-021 FSM transitions:
- RST -> RUN on the first edge with rst=1;
- RUN -> FAIL on a mismatch;
- FAIL stays FAIL and comparisons continue;
- any state -> RST on an edge with rst=0.
REQ-022 check_count SHALL increment on every comparison, wrapping from 65535 to 0.
REQ-023 err_count SHALL increment on every mismatch and saturate at 2^ERRW-1.
REQ-024 A mismatch SHALL set err_sticky in the same update as err_count.
REQ-025 The first comparison after reset SHALL expect Q=0, the required counter reset value.
REQ-026 Consecutive mismatches SHALL each be counted, with each one compared against the resynced model.

Reset
REQ-027 On an edge with rst=0, the following SHALL be cleared to 0: exp, chk_valid, mismatch, err_sticky, err_count, check_count, first_exp, first_obs and first_idx; state SHALL go to RST.
REQ-028 A reset asserted mid-run, including while in FAIL, SHALL discard all history, and no comparison SHALL occur on that edge.

Configuration
REQ-029 Macro COUNTER_MONITOR_CAPTURE_EN:
- When defined: on the first mismatch after reset, first_exp, first_obs and first_idx SHALL latch exp, Q and check_count, and hold until reset.
- When undefined: those ports SHALL exist and be driven constantly to 0, so the port list does not change.

Verification
REQ-030 Reset release with Q=0 held, enb=0, for 3 cycles -> chk_valid=1 each cycle, mismatch=0, check_count=3, state=RUN.
REQ-031 enb=1, modo=0, with a correct counter for 18 cycles from 0 -> Q wraps 15->0 and 0->1, err_count=0, err_sticky=0.
REQ-032 enb=1, modo=1, data=4'hA, then Q=4'hA on the next edge -> no mismatch; in a second run, Q=4'h9 -> mismatch=1, err_count=1, state=FAIL; with capture enabled, first_exp=A, first_obs=9.
REQ-033 Force Q wrong for 300 consecutive cycles -> err_count=255 (saturated), err_sticky=1, and first_idx keeps the index of the first error.
REQ-034 Assert rst=0 for 1 cycle while in FAIL -> all outputs read 0 and state=RST, then RUN on the next edge with rst=1.
REQ-035 Build without COUNTER_MONITOR_CAPTURE_EN and rerun REQ-032 -> first_exp, first_obs and first_idx remain 0, and err_count still reaches 1.
